// File: rtl/casc_counter.sv
// Cascaded RADIX-digit up/down counter with a prescaled count tick, sticky wrap flag
// and a multiplexed active-low 7-segment scan output.
module casc_counter #(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int TICK_DIV = 50000,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 1
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                clr_ovf,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                ovf,
  output logic                tick,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]    DMAX  = 4'(RADIX - 1);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      4'hF:    hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  endfunction

  logic [TW-1:0]       presc_r;
  logic [SW-1:0]       sdiv_r;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] q_r;
  logic [4*DIGITS-1:0] q_nxt_s;
  logic [4*DIGITS-1:0] din_clamp_s;
  logic [DIGITS-1:0]   blank_s;
  logic [DIGITS-1:0]   an_r;
  logic [6:0]          seg_r;
  logic                ovf_r;
  logic                tc_s;
  logic                tick_s;
  logic                step_s;

  // Tick is masked while in reset so TICK_DIV=1 still reads 0 under clr_n
  assign tick_s = clr_n & (presc_r == TLAST);
  assign step_s = tick_s & en & ~load;

  // Free-running count prescaler
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_r <= '0;
    end else if (presc_r == TLAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + TW'(1);
    end
  end

  // Whole-cascade next value in one cycle; chain ends up as the terminal-count flag
  always_comb begin
    logic       chain;
    logic [3:0] d;
    chain   = 1'b1;
    d       = 4'd0;
    q_nxt_s = q_r;
    for (int i = 0; i < DIGITS; i++) begin
      d = q_r[4*i +: 4];
      if (chain) begin
        if (up) begin
          q_nxt_s[4*i +: 4] = (d == DMAX) ? 4'd0 : d + 4'd1;
        end else begin
          q_nxt_s[4*i +: 4] = (d == 4'd0) ? DMAX : d - 4'd1;
        end
      end else begin
        q_nxt_s[4*i +: 4] = d;
      end
      if (up) begin
        chain = chain & (d == DMAX);
      end else begin
        chain = chain & (d == 4'd0);
      end
    end
    tc_s = chain;
  end

  // Out-of-range load digits saturate to the top digit value
  always_comb begin
    logic [3:0] d;
    d           = 4'd0;
    din_clamp_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = din[4*i +: 4];
      if ({1'b0, d} >= 5'(RADIX)) begin
        din_clamp_s[4*i +: 4] = DMAX;
      end else begin
        din_clamp_s[4*i +: 4] = d;
      end
    end
  end

  // Counter value and sticky wrap flag; a wrap outranks a same-cycle clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (load) begin
        q_r <= din_clamp_s;
      end else if (step_s) begin
        q_r <= q_nxt_s;
      end else begin
        q_r <= q_r;
      end
      if (step_s && tc_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Leading-zero mask: a digit blanks when it and every higher digit are zero
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_s    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (q_r[4*i +: 4] == 4'd0);
      if ((BLANK != 0) && (i > 0)) begin
        blank_s[i] = upper_zero;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  // Scan divider, digit index and registered display drive
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sdiv_r <= '0;
      idx_r  <= '0;
      an_r   <= '1;
      seg_r  <= 7'h7F;
    end else begin
      if (sdiv_r == SLAST) begin
        sdiv_r <= '0;
        idx_r  <= (idx_r == ILAST) ? '0 : idx_r + IW'(1);
      end else begin
        sdiv_r <= sdiv_r + SW'(1);
        idx_r  <= idx_r;
      end
      an_r  <= ~(DIGITS'(1) << idx_r);
      seg_r <= blank_s[idx_r] ? 7'h7F : hex_seg(q_r[4*idx_r +: 4]);
    end
  end

  assign q    = q_r;
  assign tc   = tc_s;
  assign ovf  = ovf_r;
  assign tick = tick_s;
  assign an   = an_r;
  assign seg  = seg_r;

endmodule

// File: doc/casc_counter.md
CASC_COUNTER -- requirements
Module: casc_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded digits (legal 1..8).
REQ-002 SHALL have parameter RADIX, default 10, modulus of every digit (legal 2..16).
REQ-003 SHALL have parameter TICK_DIV, default 50000, clk cycles per count tick (legal >=1).
REQ-004 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit advance (legal >=1).
REQ-005 SHALL have parameter BLANK, default 1, leading-zero blanking enable.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; clr_n in 1, async active-low reset.
REQ-007 SHALL have port en in 1, count enable.
REQ-008 SHALL have port up in 1, direction: 1 = up, 0 = down.
REQ-009 SHALL have port load in 1, synchronous parallel load.
REQ-010 SHALL have port din in 4*DIGITS, load value, digit i at [4i+3:4i].
REQ-011 SHALL have port clr_ovf in 1, clears the overflow flag.
REQ-012 SHALL have port q out 4*DIGITS, counter value, digit i at [4i+3:4i].
REQ-013 SHALL have port tc out 1, terminal count.
REQ-014 SHALL have port ovf out 1, sticky wrap flag.
REQ-015 SHALL have port tick out 1, one-cycle prescaler pulse.
REQ-016 SHALL have port an out DIGITS, active-low digit select.
REQ-017 SHALL have port seg out 7, active-low segments, {g,f,e,d,c,b,a}.

Function
REQ-018 SHALL implement the prescaler as a free-running counter 0..TICK_DIV-1 that wraps; tick=1 for exactly the cycle it holds TICK_DIV-1, independent of en; TICK_DIV=1 gives tick=1 every cycle.
REQ-019 SHALL define step = tick & en & ~load; q changes only on step or load.
REQ-020 SHALL, on step with up=1, increment digit 0 and increment digit i>0 only when digits 0..i-1 all equal RADIX-1; each digit wraps RADIX-1 -> 0.
REQ-021 SHALL, on step with up=0, decrement digit 0 and decrement digit i>0 only when digits 0..i-1 all equal 0; each digit wraps 0 -> RADIX-1.
REQ-022 SHALL make all cascaded digit updates in the same cycle, with no ripple latency.
REQ-023 SHALL, on load=1, set q <= din on the next edge regardless of en/tick; any din digit >= RADIX loads as RADIX-1.
REQ-024 SHALL drive tc combinationally: 1 when (up=1 and all digits = RADIX-1) or (up=0 and all digits = 0), independent of en.
REQ-025 SHALL set ovf on the edge where step occurs while tc=1 (full wrap); ovf holds until clr_ovf=1 or reset; set wins over clr_ovf in the same cycle.
REQ-026 SHALL take a change of up effect on the next step; q is not altered by the change itself.
REQ-027 SHALL advance the scan index 0..DIGITS-1 (wrapping) once every SCAN_DIV clk cycles via its own divider.
REQ-028 SHALL register an and seg: one cycle after the scan index becomes k, an has only bit k low and seg is the hex 0-F decode of digit k of the current q.
REQ-029 SHALL, when BLANK=1, drive digit k>0 with seg=7'h7F when it and all higher digits are 0; digit 0 is never blanked.
REQ-030 SHALL have no minimum hold on load: a single-cycle pulse is sufficient, and load held high reloads every cycle.

Reset
REQ-031 SHALL, while clr_n=0, asynchronously force q=0, ovf=0, prescaler=0, scan index=0, scan divider=0, an=all ones, seg=7'h7F; tick=0 and tc=up ? 0 : 1.
REQ-032 SHALL, on clr_n release, start the prescaler from 0, giving the first tick on the TICK_DIV-th rising edge after release; a reset mid-count discards all state.

Verification (DIGITS=4, RADIX=10, TICK_DIV=2, SCAN_DIV=4, BLANK=1)
REQ-033 SHALL cover: reset, en=1, up=1, 20 ticks -> q=16'h0020, tc=0, ovf=0; tick on every 2nd cycle.
REQ-034 SHALL cover: load din=16'h9998, then 2 ticks -> q=16'h9999 with tc=1, then 16'h0000 with ovf=1; clr_ovf -> ovf=0.
REQ-035 SHALL cover: up=0, q=0, 1 tick -> q=16'h9999, ovf=1; same-cycle clr_ovf at the wrap -> ovf stays 1.
REQ-036 SHALL cover: load din=16'h0F3C -> q=16'h0939; load asserted on a tick cycle -> q=din, no step, ovf unchanged.
REQ-037 SHALL cover: q=16'h0042, en=0 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg = decode 2, decode 4, 7F, 7F.
REQ-038 SHALL cover: clr_n pulsed low mid-count with an active -> q=0, an=4'hF, seg=7'h7F immediately, without waiting for clk.
